// File: rtl/fir_pipe.sv
// fir_pipe: block FIR filter with one-tap-per-cycle MAC pipeline over on-chip sample, coefficient and output memories.
module fir_pipe #(
  parameter int DATA_W = 64,
  parameter int TAPS = 100,
  parameter int SIG_LEN = 1000,
  parameter logic [DATA_W-1:0] MODULUS = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] x,
  input  logic [2:0]        operation,
  output logic [DATA_W-1:0] y,
  output logic              busy,
  output logic              done
);
  localparam int PW = 2 * DATA_W;
  localparam int AW = PW + $clog2(TAPS);
  localparam int JW = SIG_LEN > 1 ? $clog2(SIG_LEN) : 1;
  localparam int KW = TAPS > 1 ? $clog2(TAPS) : 1;
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0] in_mem [SIG_LEN];
  logic [DATA_W-1:0] coef_mem [TAPS];
  logic [DATA_W-1:0] out_mem [SIG_LEN];
  logic [JW-1:0] j, n;
  logic [KW-1:0] k;
  logic [PW-1:0] prod;
  logic [AW-1:0] acc;
  logic [DATA_W-1:0] res;
  logic start, clr, k_le_j;
  assign start = operation == 3'b010;
  assign clr = operation == 3'b101;
  assign k_le_j = 32'(k) <= 32'(j);
  assign n = JW'(32'(j) - 32'(k));
  generate
    if (MODULUS == '0) begin : g_wrap
      assign res = acc[DATA_W-1:0];
    end else begin : g_mod
      assign res = DATA_W'(acc % AW'(MODULUS));
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? ISSUE : IDLE;
      ISSUE:   state_nxt = k == KW'(TAPS - 1) ? DRAIN : ISSUE;
      DRAIN:   state_nxt = k == KW'(1) ? WRITE : DRAIN;
      WRITE:   state_nxt = j == JW'(SIG_LEN - 1) ? DONE : ISSUE;
      DONE:    state_nxt = clr ? IDLE : start ? ISSUE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state == ISSUE || state == DRAIN || state == WRITE;
    done = state == DONE;
  end
  // k counts taps in ISSUE and then the two pipeline-drain cycles in DRAIN
  always_ff @(posedge clk) begin
    if (reset) begin
      j <= '0;
      k <= '0;
      prod <= '0;
      acc <= '0;
    end else begin
      k <= (state == ISSUE || state == DRAIN) && state_nxt == state ? k + 1'b1 : '0;
      j <= state == WRITE ? j + 1'b1 : busy ? j : '0;
      prod <= state == ISSUE && k_le_j ? PW'(coef_mem[k]) * PW'(in_mem[n]) : '0;
      acc <= state == WRITE ? '0 : acc + AW'(prod);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && !busy && operation == 3'b001 && addr < 32'(SIG_LEN)) in_mem[addr[JW-1:0]] <= x;
    if (!reset && !busy && operation == 3'b100 && addr < 32'(TAPS)) coef_mem[addr[KW-1:0]] <= x;
    if (!reset && state == WRITE) out_mem[j] <= res;
  end
  always_ff @(posedge clk) begin
    if (reset) y <= '0;
    else if (operation == 3'b011) y <= addr < 32'(SIG_LEN) ? out_mem[addr[JW-1:0]] : '0;
  end
endmodule

// File: tb/tb_fir_pipe.sv
// tb_fir_pipe: three fir_pipe configurations on one shared bus, checked against a direct-convolution model.
module tb_fir_pipe;
  logic clk = 0, reset = 1;
  logic [31:0] addr = 0;
  logic [15:0] x = 0;
  logic [2:0] operation = 0;
  logic [15:0] ya, yb;
  logic [7:0] yc;
  logic busy_a, done_a, busy_b, done_b, busy_c, done_c;
  int checks = 0, failures = 0;
  typedef struct {logic [15:0] a; logic [15:0] b; logic [7:0] c; int ad;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [15:0] in_m [8];
  logic [15:0] coef_m [4];
  logic [15:0] out_a [8];
  logic [15:0] out_b [8];
  logic [7:0] out_c [8];
  logic rd_v = 0;
  int n;

  always #5 clk = ~clk;

  fir_pipe #(.DATA_W(16), .TAPS(4), .SIG_LEN(8), .MODULUS(16'd0)) dut_a (
    .clk(clk), .reset(reset), .addr(addr), .x(x), .operation(operation), .y(ya), .busy(busy_a), .done(done_a));
  fir_pipe #(.DATA_W(16), .TAPS(4), .SIG_LEN(8), .MODULUS(16'd7)) dut_b (
    .clk(clk), .reset(reset), .addr(addr), .x(x), .operation(operation), .y(yb), .busy(busy_b), .done(done_b));
  fir_pipe #(.DATA_W(8), .TAPS(4), .SIG_LEN(8), .MODULUS(8'd0)) dut_c (
    .clk(clk), .reset(reset), .addr(addr), .x(x[7:0]), .operation(operation), .y(yc), .busy(busy_c), .done(done_c));

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Direct convolution over the first upto outputs for all three configurations
  function automatic void run_model(int upto);
    for (int j = 0; j < upto; j++) begin
      longint sa = 0, sc = 0;
      for (int k = 0; k < 4; k++)
        if (k <= j) begin
          logic [15:0] cv = coef_m[k];
          logic [15:0] iv = in_m[j - k];
          sa += longint'(cv) * longint'(iv);
          sc += longint'(cv[7:0]) * longint'(iv[7:0]);
        end
      out_a[j] = sa[15:0];
      out_b[j] = 16'(sa % 7);
      out_c[j] = sc[7:0];
    end
  endfunction

  task automatic op_t(logic [2:0] o, logic [31:0] a, logic [15:0] d);
    operation = o;
    addr = a;
    x = d;
    @(posedge clk);
    #1;
    operation = 0;
  endtask

  task automatic wr_s(int a, logic [15:0] d);
    op_t(3'b001, 32'(a), d);
    if (a < 8) in_m[a] = d;
  endtask

  task automatic wr_c(int a, logic [15:0] d);
    op_t(3'b100, 32'(a), d);
    if (a < 4) coef_m[a] = d;
  endtask

  task automatic rd(int a);
    exp_t e;
    e.a = a < 8 ? out_a[a] : 16'h0;
    e.b = a < 8 ? out_b[a] : 16'h0;
    e.c = a < 8 ? out_c[a] : 8'h0;
    e.ad = a;
    sb.push_back(e);
    op_t(3'b011, 32'(a), 16'h0);
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done_a && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("done_a", 16'(done_a), 16'h1);
    chk("done_b", 16'(done_b), 16'h1);
    chk("done_c", 16'(done_c), 16'h1);
    chk("busy_after_run", 16'({busy_a, busy_b, busy_c}), 16'h0);
  endtask

  task automatic run_full();
    int cnt;
    op_t(3'b010, 0, 0);
    chk("busy_after_start", 16'({busy_a, busy_b, busy_c, done_a}), 16'he);
    wait_done(cnt);
    chk("run_latency", 16'(cnt), 16'd56);
    run_model(8);
  endtask

  task automatic read_all();
    for (int i = 0; i <= 8; i++) rd(i);
  endtask

  task automatic rand_data();
    for (int i = 0; i < 8; i++) wr_s(i, 16'($urandom));
    for (int i = 0; i < 4; i++) wr_c(i, 16'($urandom));
  endtask

  always @(posedge clk) rd_v <= operation == 3'b011 && !reset;

  always @(negedge clk)
    if (rd_v) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=read_seen required=none");
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("y_a[%0d]", mon_e.ad), ya, mon_e.a);
        chk($sformatf("y_b[%0d]", mon_e.ad), yb, mon_e.b);
        chk($sformatf("y_c[%0d]", mon_e.ad), 16'(yc), 16'(mon_e.c));
      end
    end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    chk("reset_y", ya | yb | 16'(yc), 16'h0);
    chk("reset_flags", 16'({busy_a, done_a, busy_b, done_b, busy_c, done_c}), 16'h0);
    // impulse response
    for (int i = 0; i < 4; i++) wr_c(i, 16'(i + 1));
    for (int i = 0; i < 8; i++) wr_s(i, i == 0 ? 16'd1 : 16'd0);
    run_full();
    read_all();
    // out-of-range writes ignored, clear in DONE returns to IDLE
    wr_s(8, 16'h55);
    wr_c(4, 16'h77);
    op_t(3'b101, 0, 0);
    chk("clear_done", 16'({done_a, done_b, done_c, busy_a}), 16'h0);
    // modulus: all coefficients 5, all samples 3
    for (int i = 0; i < 4; i++) wr_c(i, 16'd5);
    for (int i = 0; i < 8; i++) wr_s(i, 16'd3);
    run_full();
    read_all();
    // wrap: 255*255 truncated to the low bits
    for (int i = 0; i < 4; i++) wr_c(i, i == 0 ? 16'd255 : 16'd0);
    for (int i = 0; i < 8; i++) wr_s(i, i == 0 ? 16'd255 : 16'($urandom));
    run_full();
    read_all();
    // randomized runs, started from DONE
    repeat (3) begin
      rand_data();
      run_full();
      for (int i = 0; i < 5; i++) rd($urandom_range(0, 9));
    end
    // busy protection: writes, restart and clear during the run are ignored
    rand_data();
    op_t(3'b010, 0, 0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    op_t(3'b001, 0, 16'd9);
    op_t(3'b010, 0, 0);
    op_t(3'b100, 0, 16'h1234);
    op_t(3'b101, 0, 0);
    wait_done(n);
    chk("busy_latency", 16'(n + 9), 16'd56);
    run_model(8);
    read_all();
    // reset during output j=3 keeps only out[0..2] from the aborted run
    rand_data();
    rd(0);
    op_t(3'b010, 0, 0);
    repeat (22) begin
      @(posedge clk);
      #1;
    end
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    chk("abort_flags", 16'({busy_a, done_a, busy_b, done_b, busy_c, done_c}), 16'h0);
    chk("abort_y", ya | yb | 16'(yc), 16'h0);
    run_model(3);
    read_all();
    run_full();
    read_all();
    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", 16'(sb.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_pipe.md
FIR_PIPE -- requirements
Module: fir_pipe

Interface
REQ-001 Parameter DATA_W, default 64: sample, coefficient and output width.
REQ-002 Parameter TAPS, default 100: number of coefficients.
REQ-003 Parameter SIG_LEN, default 1000: samples per block.
REQ-004 Parameter MODULUS, default 0: 0 = outputs wrap mod 2^DATA_W; nonzero = outputs reduced mod MODULUS (RNS channel use).
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 addr  input  32  sample, coefficient or output index.
REQ-008 x  input  DATA_W  write data for sample/coefficient writes.
REQ-009 operation  input  3  000 idle, 001 write sample, 010 start, 011 read output, 100 write coefficient, 101 clear done; 110/111 treated as idle.
REQ-010 y  output  DATA_W  registered read data.
REQ-011 busy  output  1  high while a filter run is in progress.
REQ-012 done  output  1  high from run completion until cleared.

Function
REQ-013 The block SHALL compute y[j] = sum over k=0..TAPS-1 of coef[k]*in[j-k], for j=0..SIG_LEN-1, with in[n]=0 for n<0; the index check replaces padding storage.
REQ-014 Products SHALL be full 2*DATA_W bits; the accumulator SHALL be 2*DATA_W+clog2(TAPS) bits and SHALL not overflow.
REQ-015 The stored output SHALL be acc[DATA_W-1:0] when MODULUS=0, else acc mod MODULUS, zero-extended to DATA_W.
REQ-016 FSM states: IDLE, ISSUE, DRAIN, WRITE, DONE.
REQ-017 IDLE: operation 010 -> ISSUE next cycle, busy=1, done=0, output index j=0, tap index k=0.
REQ-018 ISSUE: one tap per cycle into a 2-stage MAC pipeline (register product, then accumulate); after TAPS cycles -> DRAIN.
REQ-019 DRAIN: exactly 2 cycles; -> WRITE.
REQ-020 WRITE: 1 cycle; stores the result to out[j] and clears acc; j<SIG_LEN-1 -> ISSUE with j+1, k=0; j=SIG_LEN-1 -> DONE.
REQ-021 A run SHALL take SIG_LEN*(TAPS+3) cycles from the first ISSUE cycle; done=1 and busy=0 in the cycle after the final WRITE.
REQ-022 DONE: done held at 1; operation 101 -> IDLE with done=0; operation 010 -> a new run per REQ-017.
REQ-023 Operations 001/100 SHALL write in[addr]/coef[addr] only when busy=0 and addr<SIG_LEN / addr<TAPS; otherwise ignored.
REQ-024 Operation 011 SHALL load y with out[addr] on the next edge, or 0 when addr>=SIG_LEN; permitted in any state; y holds between reads.
REQ-025 While busy=1, operations 001, 010, 100 and 101 SHALL be ignored.

Reset
REQ-026 Reset SHALL force IDLE, busy=0, done=0, y=0, j=0, k=0, acc=0 and MAC pipeline registers to 0, overriding any concurrent operation.
REQ-027 Reset SHALL not clear sample, coefficient or output memories; a reset mid-run aborts it, and out[] keeps only entries already written.

Verification (DATA_W=16, TAPS=4, SIG_LEN=8 unless stated)
REQ-028 Impulse: coef=1,2,3,4; in[0]=1, rest 0; start -> y reads 1,2,3,4,0,0,0,0; done rises 56 cycles after first ISSUE.
REQ-029 Modulus: MODULUS=7, coef all 5, in all 3 -> out = 1,2,3,4,4,4,4,4.
REQ-030 Wrap: DATA_W=8, MODULUS=0, coef[0]=255, others 0, in[0]=255 -> out[0]=1.
REQ-031 Busy protection: sample write in[0]=9 and a second start during a run -> ignored; results match the pre-run data; done timing unchanged.
REQ-032 Reset mid-run at j=3 -> busy=0, done=0, y=0 next cycle; out[0..2] valid; a new start yields the full correct result.
REQ-033 Boundaries: write addr=8 and coef addr=4 ignored; read addr=8 -> y=0; op 101 in DONE -> done=0, IDLE.
